// File: rtl/apb_requester_if.sv
// Signal bundle for apb_requester: upstream request/response channels plus
// the APB requester outputs and completer returns. The "master" modport is
// the requester's own view; "slave" is the view of whatever surrounds it
// (upstream client and APB completer together).
interface apb_requester_if;
    // Upstream request channel
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_write;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic [2:0]  req_prot;

    // Upstream response channel
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    // APB requester outputs
    logic [31:0] out_paddr;
    logic        out_psel;
    logic        out_penable;
    logic [2:0]  out_pprot;
    logic        out_pwrite;
    logic [31:0] out_pwdata;
    logic [3:0]  out_pstrb;

    // APB completer returns
    logic        out_pready;
    logic [31:0] out_prdata;
    logic        out_pslverr;

    modport master (
        input  req_valid, req_addr, req_write, req_wdata, req_wstrb, req_prot,
        output req_ready,
        output resp_valid, resp_rdata, resp_err,
        input  resp_ready,
        output out_paddr, out_psel, out_penable, out_pprot, out_pwrite,
        output out_pwdata, out_pstrb,
        input  out_pready, out_prdata, out_pslverr
    );

    modport slave (
        output req_valid, req_addr, req_write, req_wdata, req_wstrb, req_prot,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_err,
        output resp_ready,
        input  out_paddr, out_psel, out_penable, out_pprot, out_pwrite,
        input  out_pwdata, out_pstrb,
        output out_pready, out_prdata, out_pslverr
    );
endinterface

// File: rtl/apb_requester.sv
// Single-outstanding APB requester. Takes one request from a valid/ready
// channel, runs a SETUP/ACCESS APB transfer with a wait-state timeout, and
// returns read data / error on a valid/ready response channel. Every bus and
// response output is driven straight from a flop.
module apb_requester #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            clock,
    input  logic            reset,
    apb_requester_if.master bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Counter value on the ACCESS cycle that would push it to TIMEOUT.
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t      state_q,      state_d;
    logic [15:0] cnt_q,        cnt_d;
    logic        req_ready_q,  req_ready_d;
    logic        psel_q,       psel_d;
    logic        penable_q,    penable_d;
    logic [31:0] paddr_q,      paddr_d;
    logic        pwrite_q,     pwrite_d;
    logic [31:0] pwdata_q,     pwdata_d;
    logic [3:0]  pstrb_q,      pstrb_d;
    logic [2:0]  pprot_q,      pprot_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q,   resp_err_d;

    logic accept;

    // req_ready_q is high exactly while in IDLE, so this is the handshake.
    assign accept = bus.req_valid && req_ready_q;

    // Next-state and next-output computation for the transfer sequencer
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_ready_d  = req_ready_q;
        psel_d       = psel_q;
        penable_d    = penable_q;
        paddr_d      = paddr_q;
        pwrite_d     = pwrite_q;
        pwdata_d     = pwdata_q;
        pstrb_d      = pstrb_q;
        pprot_d      = pprot_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    paddr_d     = bus.req_addr;
                    pwrite_d    = bus.req_write;
                    pwdata_d    = bus.req_wdata;
                    // Reads never carry byte strobes.
                    pstrb_d     = bus.req_write ? bus.req_wstrb : 4'b0000;
                    pprot_d     = bus.req_prot;
                    psel_d      = 1'b1;
                    penable_d   = 1'b0;
                    cnt_d       = 16'd0;
                    req_ready_d = 1'b0;
                    state_d     = SETUP;
                end
            end

            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end

            ACCESS: begin
                // pready wins over a timeout landing on the same cycle.
                if (bus.out_pready) begin
                    resp_rdata_d = pwrite_q ? 32'h0 : bus.out_prdata;
                    resp_err_d   = bus.out_pslverr;
                    resp_valid_d = 1'b1;
                    psel_d       = 1'b0;
                    penable_d    = 1'b0;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                    if (cnt_q == CNT_LAST) begin
                        resp_rdata_d = 32'h0;
                        resp_err_d   = 1'b1;
                        resp_valid_d = 1'b1;
                        psel_d       = 1'b0;
                        penable_d    = 1'b0;
                        state_d      = RESP;
                    end
                end
            end

            RESP: begin
                if (bus.resp_ready) begin
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                    state_d      = IDLE;
                end
            end

            default: begin
                state_d     = IDLE;
                psel_d      = 1'b0;
                penable_d   = 1'b0;
                req_ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers; reset parks the block in IDLE with the bus quiet
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 16'd0;
            req_ready_q  <= 1'b1;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            paddr_q      <= 32'h0;
            pwrite_q     <= 1'b0;
            pwdata_q     <= 32'h0;
            pstrb_q      <= 4'b0000;
            pprot_q      <= 3'b000;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_ready_q  <= req_ready_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            paddr_q      <= paddr_d;
            pwrite_q     <= pwrite_d;
            pwdata_q     <= pwdata_d;
            pstrb_q      <= pstrb_d;
            pprot_q      <= pprot_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign bus.req_ready   = req_ready_q;
    assign bus.out_psel    = psel_q;
    assign bus.out_penable = penable_q;
    assign bus.out_paddr   = paddr_q;
    assign bus.out_pwrite  = pwrite_q;
    assign bus.out_pwdata  = pwdata_q;
    assign bus.out_pstrb   = pstrb_q;
    assign bus.out_pprot   = pprot_q;
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_rdata  = resp_rdata_q;
    assign bus.resp_err    = resp_err_q;

endmodule
